// File: rtl/life_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// life_sequencer_pkg
// Shared types and constants for the life array sequencer: FSM state encoding,
// the four built-in seed patterns and the quadrant count.
// Seed words are row-major within a 4x4 quadrant, bit 15 = top-left cell.
// Quadrants: 0 = top-left, 1 = top-right, 2 = bottom-left, 3 = bottom-right.
// -----------------------------------------------------------------------------
package life_sequencer_pkg;

   localparam int unsigned NUM_QUADS = 4;
   localparam logic [1:0]  QUAD_LAST = 2'(NUM_QUADS - 1);

   // Encoding doubles as the state_leds value.
   typedef enum logic [1:0] {
      StLoad  = 2'd0,
      StPause = 2'd1,
      StRun   = 2'd2
   } state_e;

   // [pattern][quadrant]
   localparam logic [15:0] SEED [4][4] = '{
      '{16'h42E0, 16'h0000, 16'h0000, 16'h0000},  // glider, top-left
      '{16'h0003, 16'h0008, 16'h0000, 16'h0000},  // blinker across the centre
      '{16'h0001, 16'h0008, 16'h1000, 16'h8000},  // block at the centre
      '{16'h0001, 16'h00C8, 16'h0000, 16'h8000}   // R-pentomino at the centre
   };

endpackage

// File: rtl/life_sequencer_if.sv
// -----------------------------------------------------------------------------
// life_sequencer_if
// Bundles the board-side controls and the life-array-side outputs of the
// sequencer.
//   master : the sequencer (consumes frame/buttons, drives array controls)
//   slave  : the environment (VESA driver, board inputs, life array)
// -----------------------------------------------------------------------------
interface life_sequencer_if;

   logic        frame;
   logic        run_sw;
   logic        step_btn;
   logic        load_btn;
   logic [1:0]  pattern_sel;
   logic [15:0] vali;
   logic [1:0]  vali_selector;
   logic        write_enb;
   logic        step;
   logic [15:0] gen_count;
   logic        busy;
   logic [1:0]  state_leds;

   modport master (
      input  frame, run_sw, step_btn, load_btn, pattern_sel,
      output vali, vali_selector, write_enb, step, gen_count, busy, state_leds
   );

   modport slave (
      output frame, run_sw, step_btn, load_btn, pattern_sel,
      input  vali, vali_selector, write_enb, step, gen_count, busy, state_leds
   );

endinterface

// File: rtl/life_sequencer_edge_sync.sv
// -----------------------------------------------------------------------------
// life_sequencer_edge_sync
// Multi-flop synchroniser for an asynchronous level followed by a registered
// rising-edge detector.
//   clk     : system clock
//   reset   : synchronous, active-high
//   i_async : asynchronous input level
//   o_level : synchronised level (SYNC_STAGES flops)
//   o_rise  : one-cycle pulse, SYNC_STAGES+1 cycles after the async rise
// -----------------------------------------------------------------------------
module life_sequencer_edge_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_level,
   output logic o_rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_rise;

   // The history register always follows the synchronised level, including
   // during reset, so a button held through reset yields no edge afterwards.
   always_ff @(posedge clk) begin
      r_sync[0] <= i_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[SYNC_STAGES-1];
      if (reset) begin
         r_rise <= 1'b0;
      end else begin
         r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  = r_rise;

endmodule

// File: rtl/life_sequencer.sv
// -----------------------------------------------------------------------------
// life_sequencer
// Seeds the 8x8 life array after reset or on a load request, then advances
// generations with frame-aligned one-cycle step pulses, free-running every
// FRAMES_PER_GEN frames or single-stepped from a button.
//   clk   : pixel clock shared with the VESA driver
//   reset : synchronous, active-high
//   bus   : life_sequencer_if.master
//           in : frame, run_sw, step_btn, load_btn, pattern_sel
//           out: vali, vali_selector, write_enb, step, gen_count, busy,
//                state_leds
// All outputs are registered.
// -----------------------------------------------------------------------------
module life_sequencer
   import life_sequencer_pkg::*;
#(
   parameter int unsigned FRAMES_PER_GEN = 30,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input logic               clk,
   input logic               reset,
   life_sequencer_if.master  bus
);

   localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_GEN - 1);

   logic w_run_lvl;
   logic w_run_rise;
   logic w_step_rise;
   logic w_load_lvl;
   logic w_load_rise;

   state_e      r_state;
   logic [1:0]  r_quad;
   logic [1:0]  r_pattern;
   logic [7:0]  r_frame_cnt;
   logic        r_step_pending;
   logic [15:0] r_gen_count;
   logic [15:0] r_vali;
   logic [1:0]  r_vali_sel;
   logic        r_write_enb;
   logic        r_step;
   logic        r_busy;
   logic [1:0]  r_state_leds;

   life_sequencer_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_run (
      .clk     (clk),
      .reset   (reset),
      .i_async (bus.run_sw),
      .o_level (w_run_lvl),
      .o_rise  (w_run_rise)
   );

   life_sequencer_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_step (
      .clk     (clk),
      .reset   (reset),
      .i_async (bus.step_btn),
      .o_level (),
      .o_rise  (w_step_rise)
   );

   life_sequencer_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
      .clk     (clk),
      .reset   (reset),
      .i_async (bus.load_btn),
      .o_level (w_load_lvl),
      .o_rise  (w_load_rise)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= StLoad;
         r_quad         <= 2'd0;
         r_pattern      <= 2'd0;
         r_frame_cnt    <= 8'd0;
         r_step_pending <= 1'b0;
         r_gen_count    <= 16'd0;
         r_vali         <= 16'd0;
         r_vali_sel     <= 2'd0;
         r_write_enb    <= 1'b0;
         r_step         <= 1'b0;
         r_busy         <= 1'b0;
         r_state_leds   <= StLoad;
      end else begin
         r_step       <= 1'b0;
         r_write_enb  <= 1'b0;
         r_busy       <= 1'b0;
         // state_leds lags r_state by one cycle so it lines up with the
         // other registered outputs produced from that state.
         r_state_leds <= r_state;
         if (r_step) begin
            r_gen_count <= r_gen_count + 16'd1;
         end

         unique case (r_state)
            StLoad: begin
               // Frames and buttons are ignored while loading.
               r_write_enb <= 1'b1;
               r_busy      <= 1'b1;
               r_vali      <= SEED[r_pattern][r_quad];
               r_vali_sel  <= r_quad;
               r_quad      <= r_quad + 2'd1;
               if (r_quad == QUAD_LAST) begin
                  r_state <= w_run_lvl ? StRun : StPause;
               end
            end

            StPause, StRun: begin
               if (w_load_rise) begin
                  // Load takes priority over any step due this cycle.
                  r_pattern      <= bus.pattern_sel;
                  r_state        <= StLoad;
                  r_quad         <= 2'd0;
                  r_gen_count    <= 16'd0;
                  r_frame_cnt    <= 8'd0;
                  r_step_pending <= 1'b0;
               end else if (r_state == StPause) begin
                  if (bus.frame && r_step_pending) begin
                     r_step         <= 1'b1;
                     // A press landing on the consuming frame stays queued.
                     r_step_pending <= w_step_rise;
                  end else if (w_step_rise) begin
                     r_step_pending <= 1'b1;
                  end
                  if (w_run_lvl) begin
                     r_state     <= StRun;
                     r_frame_cnt <= 8'd0;
                  end
               end else begin
                  if (bus.frame) begin
                     if (r_frame_cnt == LAST_FRAME) begin
                        r_step      <= 1'b1;
                        r_frame_cnt <= 8'd0;
                     end else begin
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                     end
                  end
                  // Switching to run discards any single-step queued before.
                  if (w_run_rise) begin
                     r_step_pending <= 1'b0;
                  end
                  if (!w_run_lvl) begin
                     r_state <= StPause;
                  end
               end
            end

            default: r_state <= StLoad;
         endcase
      end
   end

   assign bus.vali          = r_vali;
   assign bus.vali_selector = r_vali_sel;
   assign bus.write_enb     = r_write_enb;
   assign bus.step          = r_step;
   assign bus.gen_count     = r_gen_count;
   assign bus.busy          = r_busy;
   assign bus.state_leds    = r_state_leds;

   // The load level itself is not needed, only its edge.
   logic w_unused;
   assign w_unused = w_load_lvl;

endmodule

// File: tb/tb_life_sequencer.sv
// -----------------------------------------------------------------------------
// tb_life_sequencer
// Directed self-checking bench. u_dut runs with FRAMES_PER_GEN=3; u_dut2 runs
// with FRAMES_PER_GEN=1 and a frame every cycle so its gen_count reaches the
// wrap point within the run.
// -----------------------------------------------------------------------------
module tb_life_sequencer;

   logic clk;
   logic reset;
   logic reset2;

   int unsigned n_asserts;
   int unsigned n_fail;
   int unsigned n_wait;

   life_sequencer_if bus ();
   life_sequencer_if bus2 ();

   life_sequencer #(.FRAMES_PER_GEN(3), .SYNC_STAGES(2)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   life_sequencer #(.FRAMES_PER_GEN(1), .SYNC_STAGES(2)) u_dut2 (
      .clk   (clk),
      .reset (reset2),
      .bus   (bus2.master)
   );

   // Hand-written seed words (row-major, bit 15 = top-left).
   logic [15:0] exp_seed0 [4] = '{16'h42E0, 16'h0000, 16'h0000, 16'h0000};
   logic [15:0] exp_seed2 [4] = '{16'h0001, 16'h0008, 16'h1000, 16'h8000};
   logic [15:0] exp_seed3 [4] = '{16'h0001, 16'h00C8, 16'h0000, 16'h8000};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One-cycle frame pulse; step is checked in the cycle after it and the
   // cycle after that, then the bench idles for the rest of the frame period.
   task automatic frame_pulse(input string tag, input logic exp_step, input int gap);
      bus.frame = 1'b1;
      tick();
      check({tag, "_step"}, 32'(bus.step), 32'(exp_step));
      bus.frame = 1'b0;
      tick();
      check({tag, "_step_off"}, 32'(bus.step), 32'd0);
      repeat (gap) tick();
   endtask

   task automatic press_step();
      bus.step_btn = 1'b1;
      repeat (4) tick();
      check("pause_no_early_step", 32'(bus.step), 32'd0);
      bus.step_btn = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      n_asserts        = 0;
      n_fail           = 0;
      reset            = 1'b1;
      reset2           = 1'b1;
      bus.frame        = 1'b0;
      bus.run_sw       = 1'b0;
      bus.step_btn     = 1'b0;
      bus.load_btn     = 1'b0;
      bus.pattern_sel  = 2'd0;
      bus2.frame       = 1'b1;
      bus2.run_sw      = 1'b1;
      bus2.step_btn    = 1'b0;
      bus2.load_btn    = 1'b0;
      bus2.pattern_sel = 2'd0;

      // Reset held for 3 cycles.
      repeat (3) tick();
      check("rst_write_enb", 32'(bus.write_enb), 32'd0);
      check("rst_step", 32'(bus.step), 32'd0);
      check("rst_vali", 32'(bus.vali), 32'd0);
      check("rst_sel", 32'(bus.vali_selector), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_leds", 32'(bus.state_leds), 32'd0);
      check("rst_gen", 32'(bus.gen_count), 32'd0);

      // Auto-seed of pattern 0.
      reset  = 1'b0;
      reset2 = 1'b0;
      for (int q = 0; q < 4; q++) begin
         tick();
         check("seed0_we", 32'(bus.write_enb), 32'd1);
         check("seed0_busy", 32'(bus.busy), 32'd1);
         check("seed0_sel", 32'(bus.vali_selector), 32'(q));
         check("seed0_vali", 32'(bus.vali), 32'(exp_seed0[q]));
      end
      tick();
      check("seed0_done_we", 32'(bus.write_enb), 32'd0);
      check("seed0_done_busy", 32'(bus.busy), 32'd0);
      check("seed0_done_leds", 32'(bus.state_leds), 32'd1);
      check("seed0_done_gen", 32'(bus.gen_count), 32'd0);

      // Free-run at 3 frames per generation.
      bus.run_sw = 1'b1;
      repeat (10) tick();
      check("run_leds", 32'(bus.state_leds), 32'd2);
      for (int k = 0; k < 12; k++) begin
         frame_pulse("run", (k % 3) == 2, 98);
      end
      check("run_gen4", 32'(bus.gen_count), 32'd4);

      // Load during RUN with a due step on the same cycle: load wins.
      frame_pulse("pre_load", 1'b0, 20);
      frame_pulse("pre_load", 1'b0, 20);
      bus.pattern_sel = 2'd2;
      bus.load_btn    = 1'b1;
      repeat (3) tick();
      bus.frame = 1'b1;
      tick();
      check("load_vs_step_step", 32'(bus.step), 32'd0);
      check("load_vs_step_we", 32'(bus.write_enb), 32'd0);
      check("load_vs_step_gen", 32'(bus.gen_count), 32'd0);
      bus.frame = 1'b0;
      for (int q = 0; q < 4; q++) begin
         tick();
         check("seed2_we", 32'(bus.write_enb), 32'd1);
         check("seed2_step", 32'(bus.step), 32'd0);
         check("seed2_sel", 32'(bus.vali_selector), 32'(q));
         check("seed2_vali", 32'(bus.vali), 32'(exp_seed2[q]));
         bus.frame = (q == 0);  // frame during load must be ignored
      end
      tick();
      check("seed2_done_we", 32'(bus.write_enb), 32'd0);
      check("seed2_done_step", 32'(bus.step), 32'd0);
      check("seed2_done_leds", 32'(bus.state_leds), 32'd2);
      bus.load_btn = 1'b0;
      repeat (10) tick();
      // First step after load comes on the 3rd frame.
      frame_pulse("post_load", 1'b0, 20);
      frame_pulse("post_load", 1'b0, 20);
      frame_pulse("post_load", 1'b1, 20);
      check("post_load_gen", 32'(bus.gen_count), 32'd1);

      // Paused single-stepping.
      bus.run_sw = 1'b0;
      repeat (5) tick();
      check("pause_leds", 32'(bus.state_leds), 32'd1);
      press_step();
      press_step();
      frame_pulse("pause_two_presses", 1'b1, 10);
      check("pause_gen2", 32'(bus.gen_count), 32'd2);
      frame_pulse("pause_no_request", 1'b0, 10);
      press_step();
      frame_pulse("pause_third_press", 1'b1, 10);
      check("pause_gen3", 32'(bus.gen_count), 32'd3);

      // Reset during LOAD cycle 2 restarts with pattern 0.
      bus.pattern_sel = 2'd3;
      bus.load_btn    = 1'b1;
      repeat (6) tick();
      check("seed3_q1_vali", 32'(bus.vali), 32'(exp_seed3[1]));
      tick();
      check("seed3_q2_sel", 32'(bus.vali_selector), 32'd2);
      check("seed3_q2_we", 32'(bus.write_enb), 32'd1);
      reset = 1'b1;
      tick();
      check("midrst_we", 32'(bus.write_enb), 32'd0);
      check("midrst_sel", 32'(bus.vali_selector), 32'd0);
      check("midrst_leds", 32'(bus.state_leds), 32'd0);
      reset = 1'b0;
      for (int q = 0; q < 4; q++) begin
         tick();
         check("reseed_we", 32'(bus.write_enb), 32'd1);
         check("reseed_sel", 32'(bus.vali_selector), 32'(q));
         check("reseed_vali", 32'(bus.vali), 32'(exp_seed0[q]));
      end
      tick();
      check("reseed_done_we", 32'(bus.write_enb), 32'd0);
      check("reseed_done_leds", 32'(bus.state_leds), 32'd1);
      check("reseed_done_gen", 32'(bus.gen_count), 32'd0);
      // Held load button through reset gives no new load.
      repeat (6) tick();
      check("held_load_no_reload", 32'(bus.busy), 32'd0);
      bus.load_btn = 1'b0;

      // One step per frame with FRAMES_PER_GEN=1, and gen_count wrap.
      check("f1_step", 32'(bus2.step), 32'd1);
      n_wait = 0;
      while (bus2.gen_count !== 16'hFFFF && n_wait < 70000) begin
         tick();
         n_wait++;
      end
      check("wrap_reach_ffff", 32'(bus2.gen_count), 32'h0000FFFF);
      check("wrap_step", 32'(bus2.step), 32'd1);
      check("wrap_leds", 32'(bus2.state_leds), 32'd2);
      tick();
      check("wrap_to_zero", 32'(bus2.gen_count), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
